// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// the default requester count and a small wrap-around increment helper.
package uart_tx_arbiter_pkg;

  localparam int unsigned DEFAULT_NUM_REQ = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GUARD,
    ST_WAIT,
    ST_RELEASE
  } arb_state_t;

  // (idx + 1) mod n without a divider
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requester FIFOs, the arbiter and the UART transmitter.
//   req_valid/req_last/req_data : per-requester byte stream (byte i at [8i+7:8i])
//   req_ready                   : one-cycle accept pulse to the granted requester
//   tx_data/tx_start/tx_busy    : byte-serial transmitter handshake
//   grant/active                : current owner (one-hot) and grant-held flag
// master = arbiter side, slave = requesters + transmitter side.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic [NUM_REQ-1:0]   grant;
  logic                 active;

  modport master (
    input  req_valid, req_last, req_data, tx_busy,
    output req_ready, tx_data, tx_start, grant, active
  );

  modport slave (
    output req_valid, req_last, req_data, tx_busy,
    input  req_ready, tx_data, tx_start, grant, active
  );
endinterface

// File: rtl/uart_tx_arbiter_picker.sv
// rr_priority_picker: combinational round-robin selector.
//   req   : request vector
//   ptr   : highest-priority index this round
//   win   : one-hot winner (first set bit at or after ptr, wrapping)
//   valid : at least one request set
module rr_priority_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic             valid
);
  logic [PTR_W-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte streams,
// round-robin at message granularity. A grant ends on req_last, after
// MAX_BURST bytes, or after IDLE_TIMEOUT cycles with req_valid low.
//   clk, reset : clock, synchronous active-high reset
//   bus        : uart_tx_arbiter_if master modport (requesters + transmitter)
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEFAULT_NUM_REQ,
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned IDLE_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.master  bus
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win;
  logic               win_valid;
  logic [7:0]         burst_cnt;
  logic [15:0]        idle_cnt;
  logic               done;

  logic [NUM_REQ-1:0] req_ready_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [7:0]         tx_data_q;
  logic               tx_start_q;
  logic               active_q;

  assign bus.req_ready = req_ready_q;
  assign bus.grant     = grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.active    = active_q;

  rr_priority_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .win   (win),
    .valid (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win[k]) win_idx = PTR_W'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner       <= '0;
      burst_cnt   <= '0;
      idle_cnt    <= '0;
      done        <= 1'b0;
      req_ready_q <= '0;
      grant_q     <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            grant_q   <= win;
            owner     <= win_idx;
            active_q  <= 1'b1;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            done      <= 1'b0;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.req_valid[owner]) begin
            // tx_busy gate also covers a transmitter still busy across a reset
            if (!bus.tx_busy) begin
              tx_start_q  <= 1'b1;
              req_ready_q <= grant_q;
              tx_data_q   <= bus.req_data[{owner, 3'b000} +: 8];
              burst_cnt   <= burst_cnt + 8'd1;
              done        <= bus.req_last[owner];
              idle_cnt    <= '0;
              state       <= ST_GUARD;
            end
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
            if (idle_cnt == 16'(IDLE_TIMEOUT - 1)) state <= ST_RELEASE;
          end
        end
        // one dead cycle so WAIT never samples tx_busy before it rises
        ST_GUARD: state <= ST_WAIT;
        ST_WAIT: begin
          if (!bus.tx_busy) begin
            if (done || burst_cnt == 8'(MAX_BURST)) state <= ST_RELEASE;
            else                                     state <= ST_SEND;
          end
        end
        ST_RELEASE: begin
          ptr      <= PTR_W'(wrap_inc(32'(owner), NUM_REQ));
          grant_q  <= '0;
          active_q <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
